// File: rtl/mdr_select_unit_pkg.sv
// Shared datapath definitions: default data width, bus-source count and the
// 5-bit bus-mux select codes, one per bus source.
package datapath_pkg;

  localparam int DP_WIDTH = 32;
  localparam int DP_NSRC  = 32;
  localparam int SEL_W    = 5;

  typedef logic [SEL_W-1:0] sel_t;

  localparam sel_t SEL_R0     = 5'd0;
  localparam sel_t SEL_R1     = 5'd1;
  localparam sel_t SEL_R2     = 5'd2;
  localparam sel_t SEL_R3     = 5'd3;
  localparam sel_t SEL_R4     = 5'd4;
  localparam sel_t SEL_R5     = 5'd5;
  localparam sel_t SEL_R6     = 5'd6;
  localparam sel_t SEL_R7     = 5'd7;
  localparam sel_t SEL_R8     = 5'd8;
  localparam sel_t SEL_R9     = 5'd9;
  localparam sel_t SEL_R10    = 5'd10;
  localparam sel_t SEL_R11    = 5'd11;
  localparam sel_t SEL_R12    = 5'd12;
  localparam sel_t SEL_R13    = 5'd13;
  localparam sel_t SEL_R14    = 5'd14;
  localparam sel_t SEL_R15    = 5'd15;
  localparam sel_t SEL_HI     = 5'd16;
  localparam sel_t SEL_LO     = 5'd17;
  localparam sel_t SEL_ZHI    = 5'd18;
  localparam sel_t SEL_ZLO    = 5'd19;
  localparam sel_t SEL_PC     = 5'd20;
  localparam sel_t SEL_MDR    = 5'd21;
  localparam sel_t SEL_INPORT = 5'd22;
  localparam sel_t SEL_CSIGN  = 5'd23;

endpackage

// File: rtl/mdr_select_unit_if.sv
// Control/memory/bus-mux side signals of the MDR + bus-source encoder slice.
// master = control unit / datapath driver, slave = mdr_select_unit.
interface mdr_select_unit_if
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int NSRC  = DP_NSRC
);
  logic             MDRin;
  logic             Read;
  logic [WIDTH-1:0] Mdatain;
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] MDRout_q;
  logic [NSRC-1:0]  Cin;
  sel_t             Cout;
  logic             Cvalid;
  logic             Cerr;

  modport master (
    output MDRin, Read, Mdatain, BusMuxOut, Cin,
    input  MDRout_q, Cout, Cvalid, Cerr
  );

  modport slave (
    input  MDRin, Read, Mdatain, BusMuxOut, Cin,
    output MDRout_q, Cout, Cvalid, Cerr
  );
endinterface

// File: rtl/mdr_select_unit_load_reg.sv
// Generic WIDTH-bit register with load enable and asynchronous active-low clear.
module load_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/mdr_select_unit.sv
// MDR (memory or bus load) plus lowest-index-wins encoder of bus-source strobes.
// Optional multi-hot detection on Cerr is built when ENC_ONEHOT_CHECK_EN is defined.
module mdr_select_unit
  import datapath_pkg::*;
#(
  parameter int WIDTH = DP_WIDTH,
  parameter int NSRC  = DP_NSRC
) (
  input  logic               clk,
  input  logic               clr,
  mdr_select_unit_if.slave   bus
);

  logic [WIDTH-1:0] w_mdr_d;
  logic [WIDTH-1:0] w_mdr_q;
  sel_t             w_sel;
  logic             w_valid;
  logic             w_cerr;

  assign w_mdr_d = bus.Read ? bus.Mdatain : bus.BusMuxOut;

  load_reg #(
    .WIDTH (WIDTH)
  ) u_mdr (
    .clk    (clk),
    .clr    (clr),
    .i_load (bus.MDRin),
    .i_d    (w_mdr_d),
    .o_q    (w_mdr_q)
  );

  assign bus.MDRout_q = w_mdr_q;

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    w_sel   = SEL_R0;
    w_valid = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (bus.Cin[i]) begin
        w_sel   = sel_t'(i);
        w_valid = 1'b1;
      end
    end
  end

  assign bus.Cout   = w_sel;
  assign bus.Cvalid = w_valid;

`ifdef ENC_ONEHOT_CHECK_EN
  localparam logic [NSRC-1:0] LSB_ONE = {{(NSRC-1){1'b0}}, 1'b1};

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_cerr = |(bus.Cin & (bus.Cin - LSB_ONE));

  a_onehot : assert property (@(posedge clk) !w_cerr)
    else $error("mdr_select_unit: multiple bus sources driven, Cin=%h", bus.Cin);
`else
  assign w_cerr = 1'b0;
`endif

  assign bus.Cerr = w_cerr;

endmodule

// File: tb/tb_mdr_select_unit.sv
// Directed self-checking bench for mdr_select_unit: MDR reset/load/hold and encoder.
module tb_mdr_select_unit;
  import datapath_pkg::*;

  logic clk;
  logic clr;
  int   total;
  int   bad;

  mdr_select_unit_if #(.WIDTH(32), .NSRC(32)) bus ();

  mdr_select_unit #(.WIDTH(32), .NSRC(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [31:0] one_hot;
    logic        exp_multi_err;
`ifdef ENC_ONEHOT_CHECK_EN
    exp_multi_err = 1'b1;
`else
    exp_multi_err = 1'b0;
`endif
    total = 0;
    bad   = 0;

    clr           = 1'b0;
    bus.MDRin     = 1'b1;
    bus.Read      = 1'b1;
    bus.Mdatain   = 32'hDEAD_BEEF;
    bus.BusMuxOut = 32'h0;
    bus.Cin       = 32'h0;

    // Reset held across edges while a load is requested
    @(posedge clk);
    @(posedge clk); #1;
    chk("reset_hold", bus.MDRout_q, 32'h0);
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1;
    chk("reset_release_load", bus.MDRout_q, 32'hDEAD_BEEF);

    // Memory load then hold
    @(negedge clk);
    bus.Mdatain = 32'h0000_0012;
    @(posedge clk); #1;
    chk("mem_load", bus.MDRout_q, 32'h0000_0012);
    @(negedge clk);
    bus.MDRin   = 1'b0;
    bus.Mdatain = 32'h0000_0055;
    @(posedge clk); #1;
    chk("hold_mdatain_change", bus.MDRout_q, 32'h0000_0012);
    @(negedge clk);
    bus.Read      = 1'b0;
    bus.BusMuxOut = 32'h0BAD_F00D;
    @(posedge clk); #1;
    chk("hold_read_toggle", bus.MDRout_q, 32'h0000_0012);

    // Bus load ignores Mdatain
    @(negedge clk);
    bus.Read      = 1'b0;
    bus.BusMuxOut = 32'hA5A5_0001;
    bus.Mdatain   = 32'hFFFF_FFFF;
    bus.MDRin     = 1'b1;
    @(posedge clk); #1;
    chk("bus_load", bus.MDRout_q, 32'hA5A5_0001);

    // Async clear while holding, observed before the next edge
    @(negedge clk);
    bus.Read    = 1'b1;
    bus.Mdatain = 32'h0000_0012;
    @(posedge clk); #1;
    chk("reload_12", bus.MDRout_q, 32'h0000_0012);
    @(negedge clk);
    bus.MDRin = 1'b0;
    #1 clr = 1'b0;
    #1;
    chk("async_clear_mid_hold", bus.MDRout_q, 32'h0);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    chk("after_clear_no_load", bus.MDRout_q, 32'h0);

    // Reset wins over a pending load
    @(negedge clk);
    bus.MDRin   = 1'b1;
    bus.Mdatain = 32'h0000_0077;
    #1 clr = 1'b0;
    #1;
    chk("clear_during_load", bus.MDRout_q, 32'h0);
    @(posedge clk); #1;
    chk("clear_beats_load_edge", bus.MDRout_q, 32'h0);
    @(negedge clk) clr = 1'b1;
    @(posedge clk); #1;
    chk("load_after_clear", bus.MDRout_q, 32'h0000_0077);
    @(negedge clk) bus.MDRin = 1'b0;

    // Encoder one-hot sweep
    for (int k = 0; k < 32; k++) begin
      one_hot = 32'h1 << k;
      bus.Cin = one_hot;
      #1;
      chk($sformatf("enc_cout_%0d", k), {27'h0, bus.Cout}, k);
      chk($sformatf("enc_valid_%0d", k), {31'h0, bus.Cvalid}, 32'h1);
      chk($sformatf("enc_cerr_%0d", k), {31'h0, bus.Cerr}, 32'h0);
    end

    bus.Cin = 32'h0000_0008; #1;
    chk("enc_r3", {27'h0, bus.Cout}, {27'h0, SEL_R3});
    bus.Cin = 32'h0020_0000; #1;
    chk("enc_mdr", {27'h0, bus.Cout}, {27'h0, SEL_MDR});

    bus.Cin = 32'h0; #1;
    chk("enc_idle_cout", {27'h0, bus.Cout}, 32'h0);
    chk("enc_idle_valid", {31'h0, bus.Cvalid}, 32'h0);
    chk("enc_idle_cerr", {31'h0, bus.Cerr}, 32'h0);

    // Multi-hot: lowest index wins
    bus.Cin = 32'h0010_0004; #1;
    chk("multi_pc_r2_cout", {27'h0, bus.Cout}, 32'd2);
    chk("multi_pc_r2_valid", {31'h0, bus.Cvalid}, 32'h1);
    chk("multi_pc_r2_cerr", {31'h0, bus.Cerr}, {31'h0, exp_multi_err});
    bus.Cin = 32'hC000_0000; #1;
    chk("multi_31_30_cout", {27'h0, bus.Cout}, 32'd30);
    bus.Cin = 32'hFFFF_FFFF; #1;
    chk("multi_all_cout", {27'h0, bus.Cout}, 32'd0);
    chk("multi_all_cerr", {31'h0, bus.Cerr}, {31'h0, exp_multi_err});
    bus.Cin = 32'h0010_0000; #1;
    chk("single_pc_cout", {27'h0, bus.Cout}, {27'h0, SEL_PC});
    chk("single_pc_cerr", {31'h0, bus.Cerr}, 32'h0);

    // Encoder independent of clr
    clr     = 1'b0;
    bus.Cin = 32'h0001_0000; #1;
    chk("enc_under_reset", {27'h0, bus.Cout}, {27'h0, SEL_HI});
    chk("mdr_under_reset", bus.MDRout_q, 32'h0);
    clr     = 1'b1;
    bus.Cin = 32'h0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdr_select_unit.md
Name: mdr_select_unit

Overview:
- Memory-data-register plus bus-source encoder slice of the CPU datapath.
- Holds the 32-bit MDR, loaded either from memory data or from the internal bus.
- Converts the one-hot "out" strobes of all bus sources into the 5-bit select code for the 32:1 bus multiplexer.
- Sits between the control unit, the memory interface and the bus mux.

Parameters:
- WIDTH, 32, data width of the MDR and both data inputs.
- NSRC, 32, number of source strobes into the encoder; select width is fixed at 5 bits (log2 of NSRC); other NSRC values are not supported.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- clr  input  1  reset, asynchronous, active-low; 0 clears MDR immediately.
- MDRin  input  1  MDR load enable.
- Read  input  1  MDR input select: 1 = Mdatain, 0 = BusMuxOut.
- Mdatain  input  WIDTH  data returned from memory.
- BusMuxOut  input  WIDTH  current internal bus value.
- MDRout_q  output  WIDTH  registered MDR contents, feeds the bus mux MDR input.
- Cin  input  NSRC  one-hot source strobes.
- Cout  output  5  encoded bus-mux select.
- Cvalid  output  1  high when any Cin bit is set.
- Cerr  output  1  more than one Cin bit set (see Optional Feature).

Behaviour:
- MDR reset: clr=0 forces MDRout_q=0 asynchronously, regardless of clk, MDRin or Read. Deassertion takes effect at the next rising edge.
- MDR load: at a rising clk with clr=1 and MDRin=1, MDRout_q <= (Read ? Mdatain : BusMuxOut).
  - Latency is one cycle; the new value is visible after the edge.
- MDR hold: MDRin=0 keeps the previous value. Read toggling while MDRin=0 has no effect.
- Mid-operation reset: clr falling while MDRin=1 clears MDR; reset wins over load.
- Encoder: purely combinational, zero latency, no state. clk and clr do not affect it.
- Bit map of Cin:
  - bits 0-15 = R0out..R15out
  - 16 = HIout, 17 = LOout, 18 = Zhighout, 19 = Zlowout
  - 20 = PCout, 21 = MDRout, 22 = InPortout, 23 = Cout (sign-extended constant)
  - 24-31 reserved, driven 0 by the datapath.
- Cout = index of the asserted Cin bit.
- Multiple bits set: the lowest-index set bit wins.
- Cin=0: Cout=5'd0, Cvalid=0. The downstream mux then selects R0; the control unit treats Cvalid=0 as "bus idle".
- Reserved bits 24-31 encode normally (24..31) if asserted.
- No X propagation: every Cin pattern yields a defined Cout.

Optional Feature:
- Macro ENC_ONEHOT_CHECK_EN.
- Defined: Cerr = 1 combinationally whenever two or more Cin bits are high, else 0. Simulation also issues an error message on each rising clk edge where Cerr=1.
- Undefined: Cerr is tied to 0 and there is no check logic. Cout/Cvalid behaviour is identical in both builds.

Decomposition:
- Shared package datapath_pkg holds:
  - WIDTH default
  - the 5-bit select constants SEL_R0..SEL_R15, SEL_HI=16, SEL_LO=17, SEL_ZHI=18, SEL_ZLO=19, SEL_PC=20, SEL_MDR=21, SEL_INPORT=22, SEL_CSIGN=23
  - typedef for the 5-bit select code.
- One natural sub-module: load_reg, a generic WIDTH-bit register with async active-low clr and load enable.
  - The MDR is load_reg fed by the Read-controlled 2:1 mux.
  - The encoder stays inline as a priority loop.

Test Plan:
- Reset: clr=0 with MDRin=1, Read=1, Mdatain=32'hDEADBEEF across an edge -> MDRout_q=0. Release clr -> next edge MDRout_q=32'hDEADBEEF.
- Memory load: Read=1, Mdatain=32'h0000_0012, MDRin=1 for one edge -> MDRout_q=32'h12. MDRin=0, Mdatain=32'h55 -> stays 32'h12.
- Bus load: Read=0, BusMuxOut=32'hA5A5_0001, MDRin=1 -> MDRout_q=32'hA5A50001 after one edge. Mdatain ignored.
- Async reset mid-hold: MDRout_q=32'h12, clr pulsed low between edges -> MDRout_q=0 immediately, before the next clk edge.
- Encoder one-hot sweep: Cin=1<<k for k=0..31 -> Cout=k, Cvalid=1. Examples: Cin=32'h0000_0008 -> Cout=3 (R3out); Cin=32'h0020_0000 -> Cout=21 (MDRout). Cin=0 -> Cout=0, Cvalid=0.
- Encoder multi-hot: Cin=32'h0010_0004 (PCout+R2out) -> Cout=2; with ENC_ONEHOT_CHECK_EN, Cerr=1. Cin=32'h0010_0000 -> Cout=20, Cerr=0.
